pri_dec_3x8_hold: RTL
=====================

Name: pri_dec_3x8_hold

Overview:
- Receiving end of the 8x3 priority-encoded request path: takes a 3-bit index D plus valid from the upstream encoder and drives the matching one-hot line Y[7:0].
- Each decoded line is held for a programmable number of cycles, then a programmable gap follows before the next index is accepted.
- Sits between the priority encoder output and per-line consumers (grant/strobe lines).
- valid/ready handshake on the input; the output is fully registered.

Parameters:
- HOLD_CYCLES, 4, cycles each one-hot output stays asserted; legal range 1..255.
- GAP_CYCLES, 1, cycles Y stays all-zero with ready low after a hold; legal range 0..255 (0 = back to idle immediately).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- E  input  1  block enable; 0 blocks acceptance and aborts an active hold.
- D  input  3  encoded line index (0..7).
- valid  input  1  D is valid this cycle.
- ready  output  1  block can accept D this cycle.
- Y  output  8  registered one-hot decoded output; all-zero when idle.
- busy  output  1  1 while in HOLD or GAP.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, Y=8'h00, busy=0, counter=0.
  - Reset wins over all other inputs, including mid-HOLD/GAP. Y clears on that same edge.
- ready = (state==IDLE) & E & ~rst. This is combinational from state/E/rst.
- Transfer occurs on a rising edge with valid & ready = 1. D is sampled at that edge.
- States:
  - IDLE: Y=0, busy=0.
    - On transfer: Y <= 1<<D, counter <= HOLD_CYCLES-1, go to HOLD.
    - valid while ready=0 is ignored and not queued.
  - HOLD: Y=1<<D_latched, busy=1, ready=0.
    - Each cycle with E=1: if counter==0, then Y <= 0. If GAP_CYCLES>0, counter <= GAP_CYCLES-1 and go to GAP; else go to IDLE. Otherwise counter decrements.
    - E=0 at any HOLD edge: abort. Y <= 0, go to IDLE, no gap.
  - GAP: Y=0, busy=1, ready=0.
    - When counter==0, go to IDLE; else counter decrements.
    - E has no effect in GAP.
- Timing from a transfer at edge k:
  - Y is one-hot in exactly cycles k+1 .. k+HOLD_CYCLES.
  - Y is zero in cycles k+HOLD_CYCLES+1 .. k+HOLD_CYCLES+GAP_CYCLES.
  - ready is high again in cycle k+HOLD_CYCLES+GAP_CYCLES+1.
  - Minimum accept-to-accept spacing is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Y is never multi-hot. Y transitions only between 0 and a single one-hot value, never directly one-hot to a different one-hot.
- Counter width is 8 bits. No wrap is possible within the legal parameter range.
- Out-of-range parameters (HOLD_CYCLES=0 or >255, GAP_CYCLES>255) are illegal. Elaboration must fail on them.

Optional Feature:
- Macro: PRI_DEC_HIST_EN.
- When defined:
  - Extra ports: hist_clr input 1, and hist output 8.
  - hist is a sticky register: hist <= hist | (1<<D) on each transfer edge.
  - hist_clr=1 at an edge sets hist <= 0. If a transfer occurs on the same edge, hist <= (1<<D); clear applies first, then the new bit.
  - rst clears hist to 0.
- When undefined: neither port exists, and no history logic is generated.

Test Plan:
- Reset, then HOLD=4, GAP=1, E=1. Send valid=1, D=3 at edge k. Required: Y=8'h08 in cycles k+1..k+4; Y=0 and ready=0 in cycle k+5; ready=1 in cycle k+6.
- Sweep D=0..7, each sent as soon as ready=1. Required: Y equals 8'h01, 8'h02, … 8'h80 in order; Y is never multi-hot; spacing is exactly 6 cycles.
- Hold valid=1 with D=5 during HOLD of D=2. Required: D=5 is not accepted while ready=0. It is accepted on the first ready=1 edge, and Y=8'h20 follows.
- Drop E to 0 in the 2nd HOLD cycle of D=6. Required: Y=0 on the next cycle, state returns to IDLE, no gap. ready stays 0 until E=1 again.
- Assert rst mid-GAP, and separately mid-HOLD. Required: Y=0, busy=0, ready=0 during reset; ready=1 the cycle after rst falls with E=1.
- With PRI_DEC_HIST_EN: send D=1, 4, 7. Required: hist=8'h92. Then hist_clr together with a transfer of D=0. Required: hist=8'h01.

Source files
------------

// File: rtl/pri_dec_3x8_hold.sv
// ---------------------------------------------------------------------------
// pri_dec_3x8_hold
//
// Purpose:
//   Receiving end of the 8x3 priority-encoded request path. Accepts a 3-bit
//   line index D with a valid/ready handshake and drives the matching one-hot
//   line on Y. The line is held for HOLD_CYCLES cycles. Y and ready then stay
//   low for GAP_CYCLES cycles before the next index can be accepted.
//   Y and busy are registered. ready is combinational from state, E and rst.
//
// Parameters:
//   HOLD_CYCLES : cycles each one-hot output stays asserted (1..255)
//   GAP_CYCLES  : all-zero cycles after a hold, ready low (0..255)
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  synchronous active-high reset
//   E        in   1  enable; 0 blocks acceptance and aborts an active hold
//   D        in   3  encoded line index
//   valid    in   1  D is valid this cycle
//   ready    out  1  block can accept D this cycle
//   Y        out  8  registered one-hot output, zero when idle
//   busy     out  1  high while in HOLD or GAP
//   hist_clr in   1  (PRI_DEC_HIST_EN only) clear the sticky history
//   hist     out  8  (PRI_DEC_HIST_EN only) sticky OR of all accepted lines
//
// Build option:
//   Define PRI_DEC_HIST_EN to add the hist_clr/hist ports and the
//   sticky history register.
// ---------------------------------------------------------------------------
module pri_dec_3x8_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       E,
    input  logic [2:0] D,
    input  logic       valid,
    output logic       ready,
    output logic [7:0] Y,
    output logic       busy
`ifdef PRI_DEC_HIST_EN
    ,
    input  logic       hist_clr,
    output logic [7:0] hist
`endif
);

    // Out-of-range parameters are rejected at elaboration time.
    if ((HOLD_CYCLES < 1) || (HOLD_CYCLES > 255)) begin : g_bad_hold
        $error("pri_dec_3x8_hold: HOLD_CYCLES must be in 1..255");
    end
    if ((GAP_CYCLES < 0) || (GAP_CYCLES > 255)) begin : g_bad_gap
        $error("pri_dec_3x8_hold: GAP_CYCLES must be in 0..255");
    end

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;
    localparam logic       HAS_GAP   = (GAP_CYCLES > 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic [7:0] y_q,     y_d;
    logic       busy_q,  busy_d;
    logic       ready_s;
    logic       xfer_s;

    assign ready_s = (state_q == ST_IDLE) & E & ~rst;
    assign xfer_s  = valid & ready_s;

    // Next-state, counter and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer_s) begin
                    y_d     = 8'b0000_0001 << D;
                    cnt_d   = HOLD_LOAD;
                    state_d = ST_HOLD;
                    busy_d  = 1'b1;
                end else begin
                    y_d    = 8'h00;
                    busy_d = 1'b0;
                end
            end
            ST_HOLD: begin
                if (!E) begin
                    // Abort: drop the line and return straight to idle, no gap.
                    y_d     = 8'h00;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == 8'd0) begin
                    y_d = 8'h00;
                    if (HAS_GAP) begin
                        cnt_d   = GAP_LOAD;
                        state_d = ST_GAP;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                // E is deliberately ignored here; the gap always runs out.
                if (cnt_q == 8'd0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 8'd0;
                y_d     = 8'h00;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            y_q     <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

    assign ready = ready_s;
    assign Y     = y_q;
    assign busy  = busy_q;

`ifdef PRI_DEC_HIST_EN
    logic [7:0] hist_q, hist_d;

    // Sticky history: clear takes effect first, then the new line is ORed in.
    always_comb begin
        hist_d = hist_q;
        if (hist_clr) begin
            hist_d = 8'h00;
        end else begin
            hist_d = hist_q;
        end
        if (xfer_s) begin
            hist_d = hist_d | (8'b0000_0001 << D);
        end else begin
            hist_d = hist_d;
        end
    end

    // History register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 8'h00;
        end else begin
            hist_q <= hist_d;
        end
    end

    assign hist = hist_q;
`endif

endmodule
